// File: rtl/bp_be_hardfloat_pkg.sv
// Shared floating-point types plus the FP CSR addresses, op codes and the
// packed fcsr layout used by the FP CSR unit.
package bp_be_hardfloat_pkg;

   // IEEE rounding modes as encoded in instructions and in frm
   typedef enum logic [2:0] {
      e_rne = 3'b000,
      e_rtz = 3'b001,
      e_rdn = 3'b010,
      e_rup = 3'b011,
      e_rmm = 3'b100,
      e_dyn = 3'b111
   } bsg_fp_rm_e;

   // Accrued exception flags, in fflags bit order
   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } bsg_fp_eflags_s;

   // FP CSR addresses
   localparam logic [11:0] fflags_addr_gp = 12'h001;
   localparam logic [11:0] frm_addr_gp    = 12'h002;
   localparam logic [11:0] fcsr_addr_gp   = 12'h003;

   // CSR access kinds
   typedef enum logic [1:0] {
      e_fcsr_read = 2'b00,
      e_fcsr_rw   = 2'b01,
      e_fcsr_rs   = 2'b10,
      e_fcsr_rc   = 2'b11
   } bp_be_fcsr_op_e;

   // fcsr image: frm in [7:5], fflags in [4:0]
   typedef struct packed {
      bsg_fp_rm_e     frm;
      bsg_fp_eflags_s fflags;
   } bp_be_fcsr_s;

   // True for the reserved rounding-mode encodings
   function automatic logic rm_is_reserved(input logic [2:0] rm);
      return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
   endfunction

endpackage

// File: rtl/bp_be_fp_csr_unit.sv
// Owner of fflags/frm/fcsr: sticky flag accrual from committing FP ops,
// a one-outstanding CSR read/modify/write port, and dynamic rounding-mode
// resolution for issuing FP ops.
module bp_be_fp_csr_unit
   import bp_be_hardfloat_pkg::*;
#(
   parameter int csr_data_width_p = 64,
   parameter int fflags_width_p   = 5
)(
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        csr_v_i,
   output logic                        csr_ready_o,
   input  logic [11:0]                 csr_addr_i,
   input  logic [1:0]                  csr_op_i,
   input  logic [csr_data_width_p-1:0] csr_data_i,
   output logic                        csr_v_o,
   output logic [csr_data_width_p-1:0] csr_data_o,
   output logic                        csr_illegal_o,
   input  logic                        csr_yumi_i,
   input  logic                        commit_v_i,
   input  logic [fflags_width_p-1:0]   commit_fflags_i,
   input  logic [2:0]                  issue_rm_i,
   output logic [2:0]                  issue_rm_o,
   output logic                        issue_rm_illegal_o,
   input  logic                        fs_clean_i,
   output logic                        fs_dirty_o,
   output logic [2:0]                  frm_o,
   output logic [fflags_width_p-1:0]   fflags_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   logic [0:0]                  r_state;
   logic [fflags_width_p-1:0]   r_fflags;
   logic [2:0]                  r_frm;
   logic                        r_dirty;
   logic [csr_data_width_p-1:0] r_data;
   logic                        r_illegal;

   logic [fflags_width_p-1:0]   w_eff;
   logic                        w_legal;
   logic [7:0]                  w_old;
   logic [7:0]                  w_mask;
   logic [7:0]                  w_new;
   bp_be_fcsr_s                 w_fcsr_new;
   logic                        w_accept;
   logic                        w_write;
   logic                        w_dirty_set;
   logic [fflags_width_p-1:0]   w_fflags_nxt;
   logic [2:0]                  w_frm_nxt;
   logic                        w_unused_data;

   // Mask bits above the widest CSR never matter
   assign w_unused_data = ^csr_data_i[csr_data_width_p-1:8];

   // Commits in the acceptance cycle are older than the CSR op
   assign w_eff = r_fflags | (commit_v_i ? commit_fflags_i : 5'b00000);

   assign w_accept = (r_state == ST_IDLE) && csr_v_i;
   assign w_write  = w_accept && w_legal && (csr_op_i != e_fcsr_read);

   // Address decode: old value and mask truncated to the addressed CSR width
   always_comb begin
      w_legal = 1'b1;
      w_old   = 8'h00;
      w_mask  = 8'h00;
      case (csr_addr_i)
         fflags_addr_gp: begin
            w_old  = {3'b000, w_eff};
            w_mask = {3'b000, csr_data_i[4:0]};
         end
         frm_addr_gp: begin
            w_old  = {5'b00000, r_frm};
            w_mask = {5'b00000, csr_data_i[2:0]};
         end
         fcsr_addr_gp: begin
            w_old  = {r_frm, w_eff};
            w_mask = csr_data_i[7:0];
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
   end

   // New CSR value for the requested modify operation
   always_comb begin
      w_new = w_old;
      case (csr_op_i)
         e_fcsr_rw: w_new = w_mask;
         e_fcsr_rs: w_new = w_old | w_mask;
         e_fcsr_rc: w_new = w_old & ~w_mask;
         default:   w_new = w_old;
      endcase
   end

   assign w_fcsr_new = bp_be_fcsr_s'(w_new);

   // Next fflags/frm: accrual every cycle, overridden by an accepted write
   always_comb begin
      w_fflags_nxt = w_eff;
      w_frm_nxt    = r_frm;
      if (w_write) begin
         case (csr_addr_i)
            fflags_addr_gp: w_fflags_nxt = w_new[4:0];
            frm_addr_gp:    w_frm_nxt    = w_new[2:0];
            fcsr_addr_gp: begin
               w_fflags_nxt = w_fcsr_new.fflags;
               w_frm_nxt    = w_fcsr_new.frm;
            end
            default: begin
               w_fflags_nxt = w_eff;
               w_frm_nxt    = r_frm;
            end
         endcase
      end else begin
         w_fflags_nxt = w_eff;
         w_frm_nxt    = r_frm;
      end
   end

   assign w_dirty_set = (w_write && (w_new != w_old))
                      || (commit_v_i && (commit_fflags_i != 5'b00000));

   // Architectural FP CSR state and FS-dirty tracking (set beats clean)
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_fflags <= 5'b00000;
         r_frm    <= e_rne;
         r_dirty  <= 1'b0;
      end else begin
         r_fflags <= w_fflags_nxt;
         r_frm    <= w_frm_nxt;
         if (w_dirty_set) begin
            r_dirty <= 1'b1;
         end else if (fs_clean_i) begin
            r_dirty <= 1'b0;
         end
      end
   end

   // Request/response FSM with the response held until consumed
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state   <= ST_IDLE;
         r_data    <= '0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (csr_v_i) begin
                  r_state   <= ST_RESP;
                  r_data    <= w_legal ? {{(csr_data_width_p-8){1'b0}}, w_old} : '0;
                  r_illegal <= ~w_legal;
               end
            end
            ST_RESP: begin
               if (csr_yumi_i) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign csr_ready_o   = (r_state == ST_IDLE);
   assign csr_v_o       = (r_state == ST_RESP);
   assign csr_data_o    = r_data;
   assign csr_illegal_o = r_illegal;
   assign fs_dirty_o    = r_dirty;
   assign frm_o         = r_frm;
   assign fflags_o      = r_fflags;

   // Dynamic rounding resolves against the registered frm only
   assign issue_rm_o         = (issue_rm_i == e_dyn) ? r_frm : issue_rm_i;
   assign issue_rm_illegal_o = rm_is_reserved(issue_rm_o);

endmodule

// File: doc/bp_be_fp_csr_unit.md
Name: bp_be_fp_csr_unit

Overview:
- Architectural owner of the RISC-V floating-point CSRs `fflags`, `frm` and `fcsr`.
- Consumes the `bsg_fp_eflags_s` exception flags that FP pipes produce at commit and accrues them sticky into `fflags`.
- Serves CSR read/modify/write requests through a valid/ready request port and a valid/yumi response port.
- Resolves `e_dyn` rounding modes for issuing FP ops, so it is the consumer end of the flags/rounding-mode interface the FPU drives.

Parameters:
- `csr_data_width_p`, 64 (`dword_width_gp`): CSR data path width.
- `fflags_width_p`, 5: width of `bsg_fp_eflags_s`.

Ports:
- `clk_i` input 1: single clock.
- `reset_n_i` input 1: asynchronous, active-low reset.
- `csr_v_i` input 1: CSR request valid.
- `csr_ready_o` output 1: unit can accept a request.
- `csr_addr_i` input 12: CSR address.
- `csr_op_i` input 2: `bp_be_fcsr_op_e` (read=00, rw=01, rs=10, rc=11).
- `csr_data_i` input `csr_data_width_p`: write data or set/clear mask.
- `csr_v_o` output 1: response valid.
- `csr_data_o` output `csr_data_width_p`: old CSR value, zero-extended.
- `csr_illegal_o` output 1: response is an illegal access; qualified by `csr_v_o`.
- `csr_yumi_i` input 1: response consumed.
- `commit_v_i` input 1: an FP op commits this cycle.
- `commit_fflags_i` input 5: `bsg_fp_eflags_s` of the committing op.
- `issue_rm_i` input 3: instruction rounding mode (`bsg_fp_rm_e`).
- `issue_rm_o` output 3: resolved rounding mode.
- `issue_rm_illegal_o` output 1: resolved mode is reserved (101/110/111).
- `fs_clean_i` input 1: clears the FS-dirty indication.
- `fs_dirty_o` output 1: FP CSR state modified since the last clean.
- `frm_o` output 3: current `frm`.
- `fflags_o` output 5: current `fflags`.

Behaviour:
- Reset (asynchronous, `reset_n_i`=0): state IDLE, `fflags`=0, `frm`=`e_rne`, `fs_dirty_o`=0, `csr_v_o`=0, `csr_data_o`=0, `csr_illegal_o`=0. Reset mid-request discards the request and any pending response.
- FSM has two states.
  - IDLE: `csr_ready_o`=1. `csr_v_i` high → request accepted; that edge performs the update, registers the response and moves to RESP.
  - RESP: `csr_ready_o`=0; `csr_v_o`=1, with data/illegal held stable until `csr_yumi_i`. `csr_yumi_i` → IDLE. No same-cycle re-accept, so throughput is one request per 2 cycles.
  - `csr_yumi_i` is ignored in IDLE.
- Latency: response is visible the cycle after acceptance.
- Effective old flags: `eff` = `fflags` | (`commit_v_i` ? `commit_fflags_i` : 0). Commits in the acceptance cycle are older than the CSR op.
- Address decode:
  - 0x001: value = `eff`, width 5.
  - 0x002: value = `frm`, width 3.
  - 0x003: value = {`frm`, `eff`}, width 8.
  - Any other address: `csr_illegal_o`=1, `csr_data_o`=0, no state change (commit accrual still happens).
  - `csr_op_i`=read on any address performs no write.
- Write semantics, with mask m = `csr_data_i` truncated to the CSR width:
  - rw: new = m.
  - rs: new = old | m.
  - rc: new = old & ~m.
  - Bits above the CSR width are ignored on write and read as 0.
- Reserved `frm` values 101/110 are stored (not WARL-coerced).
- Accrual without an accepted write: `fflags` <= `eff` every cycle.
- FS dirty: set on any accepted write that changes the stored value, and on `commit_v_i` with nonzero flags. `fs_clean_i` clears it; if set and clean occur in the same cycle, set wins.
- Rounding-mode resolution is combinational:
  - `issue_rm_o` = (`issue_rm_i`==`e_dyn`) ? `frm` : `issue_rm_i`.
  - `issue_rm_illegal_o` = `issue_rm_o` ∈ {101,110,111}.
  - Resolution uses registered `frm`; a same-cycle CSR write is not bypassed.

Decomposition:
- Add to `bp_be_hardfloat_pkg`:
  - CSR address constants: `fflags_addr_gp`=12'h001, `frm_addr_gp`=12'h002, `fcsr_addr_gp`=12'h003.
  - `bp_be_fcsr_op_e`.
  - Packed `bp_be_fcsr_s` {`bsg_fp_rm_e` frm; `bsg_fp_eflags_s` fflags}.
- Single module; no natural sub-module.

Test Plan:
- Reset then read `fcsr` → `csr_data_o`=0, `frm_o`=000, `fs_dirty_o`=0.
- rw `fcsr` data 0xFFFF_FFFF → response old=0; next read 0xFF; `frm_o`=111, `fflags_o`=0x1F; issue `e_dyn` → `issue_rm_o`=111, `issue_rm_illegal_o`=1.
- `fflags`=0x04; commit 0x01 in the acceptance cycle of rc `fflags` mask 0x04 → response 0x05, `fflags` becomes 0x01, `fs_dirty_o`=1.
- rw `frm`=010 while commit 0x10 → `frm_o`=010, `fflags_o`=0x10; issue `e_rtz` → 001; issue `e_dyn` → 010, illegal=0.
- Read addr 0x7C0 → `csr_illegal_o`=1, data 0, state unchanged. Hold `csr_yumi_i`=0 for 5 cycles → `csr_v_o`/data stable, `csr_ready_o`=0.
- Assert `reset_n_i` low while in RESP → `csr_v_o` drops asynchronously, `fflags`/`frm` cleared, `csr_ready_o`=1 after release.
